// File: rtl/decoder_pkg.sv
// Shared definitions for the fetch/execute pair: datapath width, FSM state
// encoding and the opcode map.
package decoder_pkg;

  // Accumulator / operand width, also used by the fetch state machine.
  localparam int BYTE_WIDTH = 8;

  // Execution-stage states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Opcode map (high byte of the instruction word).
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h02;
  localparam logic [7:0] OP_SUB = 8'h03;
  localparam logic [7:0] OP_AND = 8'h04;
  localparam logic [7:0] OP_OR  = 8'h05;
  localparam logic [7:0] OP_XOR = 8'h06;
  localparam logic [7:0] OP_SHL = 8'h07;
  localparam logic [7:0] OP_SHR = 8'h08;
  localparam logic [7:0] OP_OUT = 8'h09;
  localparam logic [7:0] OP_MUL = 8'h0A;

  // Opcodes are dense from NOP to MUL; anything above is illegal.
  function automatic logic is_legal(input logic [7:0] opcode);
    return opcode <= OP_MUL;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned BYTE x BYTE multiplier. The go edge performs the first
// shift-add step while loading the operands, so MUL_CYCLES steps finish
// MUL_CYCLES-1 edges after go; done is high for the cycle that follows the
// last step.
module shift_add_mul
  import decoder_pkg::*;
#(
  parameter int BYTE       = BYTE_WIDTH,
  parameter int MUL_CYCLES = BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [BYTE-1:0]   a,
  input  logic [BYTE-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*BYTE-1:0] product
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic [2*BYTE-1:0] mcand_reg;
  logic [BYTE-1:0]   mplier_reg;
  logic [2*BYTE-1:0] product_reg;
  logic [CW-1:0]     count_reg;
  logic              busy_reg;
  logic              done_reg;

  // Load-and-first-step on go, then one shift-add step per cycle while busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      product_reg <= '0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (go && !busy_reg) begin
        product_reg <= b[0] ? {{BYTE{1'b0}}, a} : '0;
        mcand_reg   <= {{BYTE{1'b0}}, a} << 1;
        mplier_reg  <= b >> 1;
        count_reg   <= CW'(1);
        busy_reg    <= (MUL_CYCLES > 1);
        done_reg    <= (MUL_CYCLES == 1);
      end else if (busy_reg) begin
        if (mplier_reg[0]) begin
          product_reg <= product_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + CW'(1);
        if (count_reg == CW'(MUL_CYCLES - 1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: rtl/instr_decoder.sv
// Execution stage behind the instruction fetch FSM: accepts one instruction
// per start/ready handshake and executes it against an accumulator with
// zero/carry flags. MUL runs on the iterative shift_add_mul unit.
module instr_decoder
  import decoder_pkg::*;
#(
  parameter int BYTE       = BYTE_WIDTH,
  parameter int WIDTH_IN   = 2 * BYTE,
  parameter int MUL_CYCLES = BYTE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH_IN-1:0] data_in,
  output logic                ready,
  output logic [BYTE-1:0]     acc,
  output logic                zero,
  output logic                carry,
  output logic                out_valid,
  output logic [BYTE-1:0]     out_data,
  output logic                illegal
);

  localparam int SHW = $clog2(BYTE);

  state_t              state_reg, state_next;
  logic [WIDTH_IN-1:0] instr_reg, instr_next;
  logic [BYTE-1:0]     opcode_reg, opcode_next;
  logic [BYTE-1:0]     acc_reg, acc_next;
  logic                zero_reg, zero_next;
  logic                carry_reg, carry_next;
  logic                out_valid_reg, out_valid_next;
  logic [BYTE-1:0]     out_data_reg, out_data_next;
  logic                illegal_reg, illegal_next;

  logic [BYTE-1:0]     opcode_field;
  logic [BYTE-1:0]     operand;
  logic [SHW-1:0]      shamt;
  logic [BYTE:0]       add_wide;
  logic [BYTE:0]       sub_wide;
  logic [2*BYTE-1:0]   shl_wide;
  logic [2*BYTE-1:0]   shr_wide;

  logic                mul_go;
  logic                mul_busy;
  logic                mul_done;
  logic [2*BYTE-1:0]   mul_product;

  assign opcode_field = instr_reg[WIDTH_IN-1:BYTE];
  assign operand      = instr_reg[BYTE-1:0];
  assign shamt        = operand[SHW-1:0];

  // Bit BYTE of the widened sum/difference is the carry/borrow.
  assign add_wide = {1'b0, acc_reg} + {1'b0, operand};
  assign sub_wide = {1'b0, acc_reg} - {1'b0, operand};
  // Widened shifts: the bit adjacent to the result byte is the last bit
  // shifted out, and is 0 for a zero shift amount.
  assign shl_wide = {{BYTE{1'b0}}, acc_reg} << shamt;
  assign shr_wide = {acc_reg, {BYTE{1'b0}}} >> shamt;

  shift_add_mul #(
    .BYTE       (BYTE),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .go      (mul_go),
    .a       (acc_reg),
    .b       (operand),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Next-state, datapath and flag updates for the handshake FSM.
  always_comb begin
    state_next     = state_reg;
    instr_next     = instr_reg;
    opcode_next    = opcode_reg;
    acc_next       = acc_reg;
    zero_next      = zero_reg;
    carry_next     = carry_reg;
    out_valid_next = 1'b0;
    out_data_next  = out_data_reg;
    illegal_next   = illegal_reg;
    mul_go         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          instr_next = data_in;
          state_next = DECODE;
        end
      end

      DECODE: begin
        opcode_next = opcode_field;
        if (!is_legal(opcode_field)) begin
          illegal_next = 1'b1;
        end
        // Multiplier loads on the same edge the opcode is registered.
        mul_go     = (opcode_field == OP_MUL) && !mul_busy;
        state_next = EXEC;
      end

      EXEC: begin
        state_next = DONE;
        case (opcode_reg)
          OP_LD: begin
            acc_next  = operand;
            zero_next = (operand == '0);
          end
          OP_ADD: begin
            acc_next   = add_wide[BYTE-1:0];
            carry_next = add_wide[BYTE];
            zero_next  = (add_wide[BYTE-1:0] == '0);
          end
          OP_SUB: begin
            acc_next   = sub_wide[BYTE-1:0];
            carry_next = sub_wide[BYTE];
            zero_next  = (sub_wide[BYTE-1:0] == '0);
          end
          OP_AND: begin
            acc_next   = acc_reg & operand;
            carry_next = 1'b0;
            zero_next  = ((acc_reg & operand) == '0);
          end
          OP_OR: begin
            acc_next   = acc_reg | operand;
            carry_next = 1'b0;
            zero_next  = ((acc_reg | operand) == '0);
          end
          OP_XOR: begin
            acc_next   = acc_reg ^ operand;
            carry_next = 1'b0;
            zero_next  = ((acc_reg ^ operand) == '0);
          end
          OP_SHL: begin
            acc_next   = shl_wide[BYTE-1:0];
            carry_next = shl_wide[BYTE];
            zero_next  = (shl_wide[BYTE-1:0] == '0);
          end
          OP_SHR: begin
            acc_next   = shr_wide[2*BYTE-1:BYTE];
            carry_next = shr_wide[BYTE-1];
            zero_next  = (shr_wide[2*BYTE-1:BYTE] == '0);
          end
          OP_OUT: begin
            out_valid_next = 1'b1;
            out_data_next  = acc_reg;
          end
          OP_MUL: begin
            if (mul_done) begin
              acc_next   = mul_product[BYTE-1:0];
              carry_next = (mul_product[2*BYTE-1:BYTE] != '0);
              zero_next  = (mul_product[BYTE-1:0] == '0);
            end else begin
              state_next = EXEC;
            end
          end
          default: begin
            // NOP and illegal opcodes leave acc and flags untouched.
          end
        endcase
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      instr_reg     <= '0;
      opcode_reg    <= '0;
      acc_reg       <= '0;
      zero_reg      <= 1'b1;
      carry_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      illegal_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      instr_reg     <= instr_next;
      opcode_reg    <= opcode_next;
      acc_reg       <= acc_next;
      zero_reg      <= zero_next;
      carry_reg     <= carry_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      illegal_reg   <= illegal_next;
    end
  end

  assign ready     = (state_reg == IDLE);
  assign acc       = acc_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign illegal   = illegal_reg;

endmodule
